// File: rtl/bgpu_axi_mem_bridge.sv
// bgpu_axi_mem_bridge: AXI4 subordinate terminating the debug-bus AXI port
// onto a single-port, word-addressed SRAM. One burst in flight at a time,
// round-robin between reads and writes, per-beat error responses.

package bgpu_axi_mem_bridge_pkg;
    localparam int unsigned AxiAddrWidth = 32;
    localparam int unsigned AxiDataWidth = 32;
    localparam int unsigned AxiIdWidth   = 1;
    localparam int unsigned AxiUserWidth = 1;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [5:0]              atop;
        logic [AxiUserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [AxiDataWidth-1:0]   data;
        logic [AxiDataWidth/8-1:0] strb;
        logic                      last;
        logic [AxiUserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [1:0]              resp;
        logic [AxiUserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiAddrWidth-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
        logic [3:0]              region;
        logic [AxiUserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [AxiIdWidth-1:0]   id;
        logic [AxiDataWidth-1:0] data;
        logic [1:0]              resp;
        logic                    last;
        logic [AxiUserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;
endpackage

module bgpu_axi_mem_bridge #(
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned IdWidth      = 1,
    parameter int unsigned MemAddrWidth = 10,
    parameter type axi_req_t = bgpu_axi_mem_bridge_pkg::axi_req_t,
    parameter type axi_rsp_t = bgpu_axi_mem_bridge_pkg::axi_rsp_t
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  axi_req_t                axi_req_i,
    output axi_rsp_t                axi_rsp_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [MemAddrWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    output logic [DataWidth/8-1:0]  mem_be_o,
    input  logic [DataWidth-1:0]    mem_rdata_i
);
    localparam int unsigned OffW     = $clog2(DataWidth / 8);
    localparam int unsigned RangeW   = MemAddrWidth + OffW;
    localparam logic [2:0]  MaxSize  = 3'(OffW);
    localparam logic [1:0]  BurstFixed = 2'b00;
    localparam logic [1:0]  BurstWrap  = 2'b10;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RD_REQ, RD_WAIT, RD_RSP} state_e;

    state_e                 state_reg, state_next;
    logic [IdWidth-1:0]     id_reg;
    logic [AddrWidth-1:0]   addr_reg;
    logic [7:0]             len_reg;
    logic [7:0]             cnt_reg;
    logic [2:0]             size_reg;
    logic [1:0]             burst_reg;
    logic                   err_reg;
    logic [DataWidth-1:0]   rdata_reg;
    logic [1:0]             rresp_reg;
    logic                   last_was_write_reg;

    logic                   grant_write, grant_read;
    logic                   beat_err, beat_last;
    logic [AddrWidth-1:0]   addr_next;
    logic                   unused_req;

    // Only a few request fields matter; fold the whole struct so nothing dangles.
    assign unused_req = ^axi_req_i;

    // Round-robin: on a tie the direction not served last wins.
    assign grant_write = axi_req_i.aw_valid & (~axi_req_i.ar_valid | ~last_was_write_reg);
    assign grant_read  = axi_req_i.ar_valid & ~grant_write;

    // Current beat is illegal if too wide, WRAP, or beyond the SRAM.
    assign beat_err  = (size_reg > MaxSize) | (burst_reg == BurstWrap)
                     | ((addr_reg >> RangeW) != '0);
    assign beat_last = (cnt_reg == len_reg);
    assign addr_next = (burst_reg == BurstFixed) ? addr_reg
                                                 : addr_reg + (AddrWidth'(1) << size_reg);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_write)     state_next = WRITE;
                else if (grant_read) state_next = RD_REQ;
            end
            WRITE:   if (axi_req_i.w_valid && beat_last) state_next = WRESP;
            WRESP:   if (axi_req_i.b_ready) state_next = IDLE;
            RD_REQ:  state_next = RD_WAIT;
            RD_WAIT: state_next = RD_RSP;
            RD_RSP:  if (axi_req_i.r_ready) state_next = beat_last ? IDLE : RD_REQ;
            default: state_next = IDLE;
        endcase
    end

    // Burst context, beat counter, sticky error and read-beat holding registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_reg             <= '0;
            addr_reg           <= '0;
            len_reg            <= '0;
            cnt_reg            <= '0;
            size_reg           <= '0;
            burst_reg          <= '0;
            err_reg            <= 1'b0;
            rdata_reg          <= '0;
            rresp_reg          <= '0;
            last_was_write_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_write) begin
                        id_reg             <= axi_req_i.aw.id;
                        addr_reg           <= axi_req_i.aw.addr;
                        len_reg            <= axi_req_i.aw.len;
                        size_reg           <= axi_req_i.aw.size;
                        burst_reg          <= axi_req_i.aw.burst;
                        cnt_reg            <= '0;
                        err_reg            <= 1'b0;
                        last_was_write_reg <= 1'b1;
                    end else if (grant_read) begin
                        id_reg             <= axi_req_i.ar.id;
                        addr_reg           <= axi_req_i.ar.addr;
                        len_reg            <= axi_req_i.ar.len;
                        size_reg           <= axi_req_i.ar.size;
                        burst_reg          <= axi_req_i.ar.burst;
                        cnt_reg            <= '0;
                        err_reg            <= 1'b0;
                        last_was_write_reg <= 1'b0;
                    end
                end
                WRITE: begin
                    if (axi_req_i.w_valid) begin
                        err_reg  <= err_reg | beat_err;
                        addr_reg <= addr_next;
                        cnt_reg  <= cnt_reg + 8'd1;
                    end
                end
                RD_WAIT: begin
                    rdata_reg <= beat_err ? '0 : mem_rdata_i;
                    rresp_reg <= beat_err ? RespSlvErr : RespOkay;
                end
                RD_RSP: begin
                    if (axi_req_i.r_ready && !beat_last) begin
                        addr_reg <= addr_next;
                        cnt_reg  <= cnt_reg + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs; everything is held quiet while reset is asserted so no handshake slips through.
    always_comb begin
        axi_rsp_o   = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (!rst_i) begin
            case (state_reg)
                IDLE: begin
                    axi_rsp_o.aw_ready = grant_write;
                    axi_rsp_o.ar_ready = grant_read;
                end
                WRITE: begin
                    axi_rsp_o.w_ready = 1'b1;
                    mem_req_o   = axi_req_i.w_valid & ~beat_err;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = addr_reg[RangeW-1:OffW];
                    mem_wdata_o = axi_req_i.w.data;
                    mem_be_o    = axi_req_i.w.strb;
                end
                WRESP: begin
                    axi_rsp_o.b_valid = 1'b1;
                    axi_rsp_o.b.id    = id_reg;
                    axi_rsp_o.b.resp  = err_reg ? RespSlvErr : RespOkay;
                end
                RD_REQ: begin
                    mem_req_o  = ~beat_err;
                    mem_addr_o = addr_reg[RangeW-1:OffW];
                    mem_be_o   = '1;
                end
                RD_RSP: begin
                    axi_rsp_o.r_valid = 1'b1;
                    axi_rsp_o.r.id    = id_reg;
                    axi_rsp_o.r.data  = rdata_reg;
                    axi_rsp_o.r.resp  = rresp_reg;
                    axi_rsp_o.r.last  = beat_last;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bgpu_axi_mem_bridge.sv
// Directed bench for bgpu_axi_mem_bridge with an SRAM model and B/R scoreboards.
module tb_bgpu_axi_mem_bridge;
    import bgpu_axi_mem_bridge_pkg::*;

    typedef struct packed {
        logic [0:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_exp_t;

    typedef struct packed {
        logic [0:0] id;
        logic [1:0] resp;
    } b_exp_t;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    logic        clk = 1'b0;
    logic        rst_i;
    axi_req_t    axi_req;
    axi_rsp_t    axi_rsp;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int          tests = 0;
    int          fails = 0;
    int          sram_acc = 0;
    int          acc0;
    logic [31:0] sram    [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] wdat    [4];
    logic [3:0]  wstrb   [4];
    r_exp_t      exp_r[$];
    b_exp_t      exp_b[$];

    always #5 clk = ~clk;

    bgpu_axi_mem_bridge #(
        .AddrWidth(32), .DataWidth(32), .IdWidth(1), .MemAddrWidth(10),
        .axi_req_t(axi_req_t), .axi_rsp_t(axi_rsp_t)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .axi_req_i(axi_req), .axi_rsp_o(axi_rsp),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
    );

    // SRAM macro model: byte-masked write, read data one cycle after request.
    always @(posedge clk) begin
        if (mem_req) begin
            sram_acc <= sram_acc + 1;
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic beat_bad(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
        return (size > 3'd2) || (burst == WRAP) || (a >= 32'h1000);
    endfunction

    function automatic logic [31:0] step(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst);
        return (burst == FIXED) ? a : a + (32'd1 << size);
    endfunction

    task automatic set_aw(input logic id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        axi_req.aw       = '0;
        axi_req.aw.id    = id;
        axi_req.aw.addr  = addr;
        axi_req.aw.len   = len;
        axi_req.aw.size  = size;
        axi_req.aw.burst = burst;
        axi_req.aw_valid = 1'b1;
    endtask

    task automatic set_ar(input logic id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
        axi_req.ar       = '0;
        axi_req.ar.id    = id;
        axi_req.ar.addr  = addr;
        axi_req.ar.len   = len;
        axi_req.ar.size  = size;
        axi_req.ar.burst = burst;
        axi_req.ar_valid = 1'b1;
    endtask

    // Expected read beats come from the reference memory at acceptance time.
    task automatic push_r_exp(input logic id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        logic        bad;
        r_exp_t      e;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            bad    = beat_bad(a, size, burst);
            e.id   = id;
            e.data = bad ? 32'h0 : ref_mem[a[11:2]];
            e.resp = bad ? 2'b10 : 2'b00;
            e.last = (i == int'(len));
            exp_r.push_back(e);
            a = step(a, size, burst);
        end
    endtask

    task automatic send_aw(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        set_aw(id, addr, len, size, burst);
        #1;
        check("aw_ready", axi_rsp.aw_ready, 1'b1);
        @(negedge clk);
        axi_req.aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        set_ar(id, addr, len, size, burst);
        push_r_exp(id, addr, len, size, burst);
        #1;
        check("ar_ready", axi_rsp.ar_ready, 1'b1);
        @(negedge clk);
        axi_req.ar_valid = 1'b0;
    endtask

    // Drives n W beats from wdat/wstrb, optionally with one idle cycle before beat stall_at.
    task automatic w_phase(input int n, input logic [31:0] addr, input logic [2:0] size,
                           input logic [1:0] burst, input logic id, input int stall_at);
        logic [31:0] a;
        logic        bad, err;
        b_exp_t      e;
        a   = addr;
        err = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                axi_req.w_valid = 1'b0;
                #1;
                check("w_stall_no_req", mem_req, 1'b0);
                @(negedge clk);
            end
            axi_req.w      = '0;
            axi_req.w.data = wdat[i];
            axi_req.w.strb = wstrb[i];
            axi_req.w.last = (i == n - 1);
            axi_req.w_valid = 1'b1;
            #1;
            bad = beat_bad(a, size, burst);
            check("w_ready", axi_rsp.w_ready, 1'b1);
            check("w_mem_req", mem_req, !bad);
            if (!bad) begin
                check("w_mem_addr", mem_addr, a[11:2]);
                check("w_mem_we", mem_we, 1'b1);
                for (int b = 0; b < 4; b++)
                    if (wstrb[i][b]) ref_mem[a[11:2]][8*b +: 8] = wdat[i][8*b +: 8];
            end
            err = err | bad;
            a   = step(a, size, burst);
            @(negedge clk);
        end
        axi_req.w_valid = 1'b0;
        e.id   = id;
        e.resp = err ? 2'b10 : 2'b00;
        exp_b.push_back(e);
    endtask

    task automatic b_phase(input int stall);
        b_exp_t e;
        int     n;
        axi_req.b_ready = 1'b0;
        #1;
        n = 0;
        while (!axi_rsp.b_valid && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("b_latency", n, 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            #1;
            check("b_hold_valid", axi_rsp.b_valid, 1'b1);
        end
        axi_req.b_ready = 1'b1;
        e = (exp_b.size() > 0) ? exp_b.pop_front() : '0;
        check("b_id", axi_rsp.b.id, e.id);
        check("b_resp", axi_rsp.b.resp, e.resp);
        @(negedge clk);
        axi_req.b_ready = 1'b0;
    endtask

    // Entered on the RD_REQ cycle of each beat; optionally stalls r_ready one cycle.
    task automatic r_phase(input int n, input bit toggle);
        r_exp_t      e;
        int          k;
        logic [31:0] held;
        for (int i = 0; i < n; i++) begin
            e = (exp_r.size() > 0) ? exp_r.pop_front() : '0;
            axi_req.r_ready = 1'b0;
            #1;
            check("rd_mem_req", mem_req, e.resp == 2'b00);
            check("rd_mem_we", mem_we, 1'b0);
            k = 0;
            while (!axi_rsp.r_valid && k < 10) begin
                @(negedge clk);
                #1;
                k++;
            end
            check("r_latency", k, 2);
            if (toggle) begin
                held = axi_rsp.r.data;
                @(negedge clk);
                #1;
                check("r_stall_valid", axi_rsp.r_valid, 1'b1);
                check("r_stall_data", axi_rsp.r.data, held);
            end
            axi_req.r_ready = 1'b1;
            check("r_id", axi_rsp.r.id, e.id);
            check("r_data", axi_rsp.r.data, e.data);
            check("r_resp", axi_rsp.r.resp, e.resp);
            check("r_last", axi_rsp.r.last, e.last);
            @(negedge clk);
            axi_req.r_ready = 1'b0;
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_aw_ready"}, axi_rsp.aw_ready, 1'b0);
        check({tag, "_ar_ready"}, axi_rsp.ar_ready, 1'b0);
        check({tag, "_w_ready"},  axi_rsp.w_ready,  1'b0);
        check({tag, "_b_valid"},  axi_rsp.b_valid,  1'b0);
        check({tag, "_r_valid"},  axi_rsp.r_valid,  1'b0);
        check({tag, "_mem_req"},  mem_req, 1'b0);
        check({tag, "_mem_we"},   mem_we,  1'b0);
        check({tag, "_mem_addr"}, mem_addr, 10'h0);
    endtask

    initial begin
        axi_req = '0;
        rst_i   = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            sram[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        for (int i = 0; i < 4; i++) wstrb[i] = 4'hF;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_quiet("rst");
        rst_i = 1'b0;
        #1;
        check_quiet("post_rst");
        @(negedge clk);

        // Single write, id echoed
        send_aw(1'b1, 32'h10, 8'd0, 3'd2, INCR);
        wdat[0] = 32'hDEADBEEF;
        w_phase(1, 32'h10, 3'd2, INCR, 1'b1, -1);
        b_phase(0);

        // Full write, strobed byte write, read back the merge
        send_aw(1'b0, 32'h0, 8'd0, 3'd2, INCR);
        wdat[0] = 32'hFFFFFFFF;
        w_phase(1, 32'h0, 3'd2, INCR, 1'b0, -1);
        b_phase(0);
        send_aw(1'b0, 32'h0, 8'd0, 3'd2, INCR);
        wdat[0] = 32'h0000AB00; wstrb[0] = 4'h2;
        w_phase(1, 32'h0, 3'd2, INCR, 1'b0, -1);
        b_phase(0);
        wstrb[0] = 4'hF;
        check("strb_merge_model", ref_mem[0], 32'hFFFFABFF);
        send_ar(1'b0, 32'h0, 8'd0, 3'd2, INCR);
        r_phase(1, 1'b0);

        // INCR burst with a W stall and B backpressure, read back with R stalls
        for (int i = 0; i < 4; i++) wdat[i] = 32'(i + 1);
        send_aw(1'b1, 32'h20, 8'd3, 3'd2, INCR);
        w_phase(4, 32'h20, 3'd2, INCR, 1'b1, 2);
        b_phase(2);
        send_ar(1'b1, 32'h20, 8'd3, 3'd2, INCR);
        r_phase(4, 1'b1);

        // FIXED burst hits the same word every beat
        wdat[0] = 32'h0000000A; wdat[1] = 32'h0000000B;
        send_aw(1'b0, 32'h30, 8'd1, 3'd2, FIXED);
        w_phase(2, 32'h30, 3'd2, FIXED, 1'b0, -1);
        b_phase(0);
        send_ar(1'b0, 32'h30, 8'd1, 3'd2, FIXED);
        r_phase(2, 1'b0);

        // WRAP write: no SRAM access, SLVERR
        acc0 = sram_acc;
        wdat[0] = 32'h55555555; wdat[1] = 32'h66666666;
        send_aw(1'b1, 32'h40, 8'd1, 3'd2, WRAP);
        w_phase(2, 32'h40, 3'd2, WRAP, 1'b1, -1);
        b_phase(0);
        check("wrap_no_sram", sram_acc, acc0);

        // Out-of-range read: data 0, SLVERR, no SRAM access
        acc0 = sram_acc;
        send_ar(1'b0, 32'h1000, 8'd0, 3'd2, INCR);
        r_phase(1, 1'b0);
        check("oor_no_sram", sram_acc, acc0);

        // Oversized beat
        send_ar(1'b1, 32'h0, 8'd0, 3'd3, INCR);
        r_phase(1, 1'b0);

        // Burst straddling the top of the SRAM
        wdat[0] = 32'h12345678; wdat[1] = 32'h9ABCDEF0;
        send_aw(1'b0, 32'hFFC, 8'd1, 3'd2, INCR);
        w_phase(2, 32'hFFC, 3'd2, INCR, 1'b0, -1);
        b_phase(0);
        send_ar(1'b1, 32'hFFC, 8'd1, 3'd2, INCR);
        r_phase(2, 1'b0);

        // Arbitration: AW and AR competing, expect write, read, write, read
        set_aw(1'b0, 32'h80, 8'd0, 3'd2, INCR);
        set_ar(1'b1, 32'h10, 8'd0, 3'd2, INCR);
        #1;
        check("arb1_aw_ready", axi_rsp.aw_ready, 1'b1);
        check("arb1_ar_ready", axi_rsp.ar_ready, 1'b0);
        @(negedge clk);
        axi_req.aw_valid = 1'b0;
        wdat[0] = 32'hA0A0A0A0;
        w_phase(1, 32'h80, 3'd2, INCR, 1'b0, -1);
        b_phase(0);
        set_aw(1'b0, 32'h84, 8'd0, 3'd2, INCR);
        #1;
        check("arb2_ar_ready", axi_rsp.ar_ready, 1'b1);
        check("arb2_aw_ready", axi_rsp.aw_ready, 1'b0);
        push_r_exp(1'b1, 32'h10, 8'd0, 3'd2, INCR);
        @(negedge clk);
        axi_req.ar_valid = 1'b0;
        r_phase(1, 1'b0);
        set_ar(1'b0, 32'h80, 8'd0, 3'd2, INCR);
        #1;
        check("arb3_aw_ready", axi_rsp.aw_ready, 1'b1);
        check("arb3_ar_ready", axi_rsp.ar_ready, 1'b0);
        @(negedge clk);
        axi_req.aw_valid = 1'b0;
        wdat[0] = 32'hB1B1B1B1;
        w_phase(1, 32'h84, 3'd2, INCR, 1'b0, -1);
        b_phase(0);
        set_aw(1'b1, 32'h88, 8'd0, 3'd2, INCR);
        #1;
        check("arb4_ar_ready", axi_rsp.ar_ready, 1'b1);
        check("arb4_aw_ready", axi_rsp.aw_ready, 1'b0);
        push_r_exp(1'b0, 32'h80, 8'd0, 3'd2, INCR);
        @(negedge clk);
        axi_req.ar_valid = 1'b0;
        r_phase(1, 1'b0);
        #1;
        check("arb5_aw_ready", axi_rsp.aw_ready, 1'b1);
        @(negedge clk);
        axi_req.aw_valid = 1'b0;
        wdat[0] = 32'hC2C2C2C2;
        w_phase(1, 32'h88, 3'd2, INCR, 1'b1, -1);
        b_phase(0);

        // Reset after 2 of 4 beats: burst dropped, SRAM keeps the beats written
        wdat[0] = 32'h11111111; wdat[1] = 32'h22222222;
        send_aw(1'b0, 32'h100, 8'd3, 3'd2, INCR);
        w_phase(2, 32'h100, 3'd2, INCR, 1'b0, -1);
        exp_b.delete();
        rst_i = 1'b1;
        @(negedge clk);
        #1;
        check_quiet("midrst");
        rst_i = 1'b0;
        @(negedge clk);
        wdat[0] = 32'h33333333;
        send_aw(1'b1, 32'h110, 8'd0, 3'd2, INCR);
        w_phase(1, 32'h110, 3'd2, INCR, 1'b1, -1);
        b_phase(0);
        send_ar(1'b0, 32'h100, 8'd3, 3'd2, INCR);
        r_phase(4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
